alu_exec_ctrl: RTL and testbench

Sequencing front-end for the 8-bit ALU. Accepts 16-bit instruction words over a valid/ready handshake, reads operands from a local 4×8 register file, and drives the ALU operand and opcode inputs. It captures the ALU result and flags, writes back to the register file, and emits one result beat downstream. Sits directly upstream of the ALU, which is instantiated beside it at the same level with its ports wired combinationally.

---
 rtl/alu_exec_ctrl_pkg.sv | 40 ++++
 rtl/alu_regfile.sv | 29 ++
 rtl/alu_exec_ctrl.sv | 116 +++++++++++
 tb/tb_alu_exec_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_ctrl_pkg.sv
// rtl/alu_exec_ctrl_pkg.sv - shared opcodes, flag indices, instruction layout and FSM encoding
package alu_exec_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_SLT = 3'b101;
    localparam logic [OP_W-1:0] OP_LDI = 3'b110;
    localparam logic [OP_W-1:0] OP_NOP = 3'b111;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    // Field order fixes the bit positions: op[15:13] rd[12:11] rs1[10:9] imm_sel[8] imm[7:0]; rs2 is imm[1:0].
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [1:0]        rd;
        logic [1:0]        rs1;
        logic              imm_sel;
        logic [DATA_W-1:0] imm;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic [DATA_W-1:0] neg8(input logic [DATA_W-1:0] x);
        return ~x + 8'd1;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 4x8 register file, one write port, two combinational read ports
module alu_regfile
    import alu_exec_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [1:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [1:0]        raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - instruction sequencer driving the 8-bit ALU with register-file write-back
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [1:0]        out_rd,
    output logic [3:0]        flags
);

    state_e            state_q, state_d;
    instr_t            instr_q;
    logic [DATA_W-1:0] out_result_q;
    logic [1:0]        out_rd_q;
    logic [3:0]        flags_q, flags_d;

    logic [DATA_W-1:0] rs1_val, rs2_val, op_a, op_b, wb_data;
    logic              rf_we, load_out;

    alu_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (rf_we),
        .waddr_i   (instr_q.rd),
        .wdata_i   (wb_data),
        .raddr_a_i (instr_q.rs1),
        .rdata_a_o (rs1_val),
        .raddr_b_i (instr_q.imm[1:0]),
        .rdata_b_o (rs2_val)
    );

    assign op_a = rs1_val;
    assign op_b = instr_q.imm_sel ? instr_q.imm : rs2_val;

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        rf_we      = 1'b0;
        load_out   = 1'b0;
        wb_data    = '0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                alu_a      = op_a;
                alu_b      = (instr_q.op == OP_SUB) ? neg8(op_b) : op_b;
                alu_opcode = (instr_q.op == OP_SUB) ? OP_ADD : instr_q.op;
                state_d    = ST_RESP;
                rf_we      = 1'b1;
                load_out   = 1'b1;
                wb_data    = alu_result;
                case (instr_q.op)
                    OP_NOP: begin
                        state_d  = ST_IDLE;
                        rf_we    = 1'b0;
                        load_out = 1'b0;
                    end
                    OP_LDI: wb_data = instr_q.imm;
                    // The ALU only adds the negated operand, so carry/overflow reflect a subtraction here.
                    OP_SUB: begin
                        flags_d        = alu_flags;
                        flags_d[FLG_C] = (op_a >= op_b);
                        flags_d[FLG_V] = (op_a[7] != op_b[7]) && (alu_result[7] != op_a[7]);
                    end
                    default: flags_d = alu_flags;
                endcase
            end
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            instr_q      <= '0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            flags_q      <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            if (state_q == ST_IDLE && in_valid) instr_q <= instr_t'(in_instr);
            if (load_out) begin
                out_result_q <= wb_data;
                out_rd_q     <= instr_q.rd;
            end
        end
    end

    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - randomized and directed bench for alu_exec_ctrl with a reference model
module tb_alu_exec_ctrl;
    import alu_exec_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_opcode;
    logic [3:0]  alu_flags;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_result;
    logic [1:0]  out_rd;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;
    int rm [4];
    logic [3:0] fm;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .flags      (flags)
    );

    // Behavioural ALU sitting beside the controller.
    always_comb begin
        int s;
        logic c, v;
        s = int'(alu_a) + int'(alu_b);
        c = 1'b0;
        v = 1'b0;
        case (alu_opcode)
            3'b000: begin
                alu_result = 8'(s);
                c = (s > 255);
                v = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = (alu_a < alu_b) ? 8'd1 : 8'd0;
            default: alu_result = 8'd0;
        endcase
        alu_flags = {v, alu_result[7], c, (alu_result == 8'd0)};
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic isel, input logic [7:0] imm, input int hold, input bit pend);
        int a, b, res, sv, guard;
        logic c, v;
        logic [3:0] fexp;
        a = rm[rs1];
        b = isel ? int'(imm) : rm[imm[1:0]];
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                res = (a + b) % 256; c = (a + b) > 255;
                sv = sgn(a) + sgn(b); v = (sv > 127) || (sv < -128);
            end
            OP_SUB: begin
                res = (a - b + 256) % 256; c = (a >= b);
                sv = sgn(a) - sgn(b); v = (sv > 127) || (sv < -128);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLT:  res = (a < b) ? 1 : 0;
            OP_LDI:  res = int'(imm);
            default: res = 0;
        endcase
        fexp = {v, (res > 127), c, (res == 0)};

        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        chk("accept_ready", 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        in_instr = {op, rd, rs1, isel, imm};
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_instr = 16'($urandom);
        chk("exec_in_ready", 16'(in_ready), 16'd0);
        if (op != OP_LDI && op != OP_NOP) begin
            chk("exec_alu_a", 16'(alu_a), 16'(a));
            chk("exec_alu_b", 16'(alu_b), 16'((op == OP_SUB) ? (256 - b) % 256 : b));
            chk("exec_alu_op", 16'(alu_opcode), 16'((op == OP_SUB) ? 0 : int'(op)));
        end
        if (op == OP_NOP) begin
            @(posedge clk); #1;
            chk("nop_no_beat", 16'(out_valid), 16'd0);
            chk("nop_ready", 16'(in_ready), 16'd1);
            chk("nop_flags", 16'(flags), 16'(fm));
            return;
        end
        chk("exec_no_beat", 16'(out_valid), 16'd0);
        @(posedge clk); #1;
        rm[rd] = res;
        if (op != OP_LDI) fm = fexp;
        chk("beat_valid", 16'(out_valid), 16'd1);
        chk("beat_result", 16'(out_result), 16'(res));
        chk("beat_rd", 16'(out_rd), 16'(rd));
        chk("beat_flags", 16'(flags), 16'(fm));
        if (pend) begin
            in_valid = 1'b1;
            in_instr = 16'($urandom);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 16'(out_valid), 16'd1);
            chk("hold_result", 16'(out_result), 16'(res));
            chk("hold_rd", 16'(out_rd), 16'(rd));
            chk("hold_in_ready", 16'(in_ready), 16'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("done_valid", 16'(out_valid), 16'd0);
        chk("done_ready", 16'(in_ready), 16'd1);
        chk("idle_alu_op", 16'({alu_a, 5'd0, alu_opcode}), 16'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rm[i] = 0;
        fm = 4'd0;
        #12;
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_flags", 16'(flags), 16'd0);
        chk("rst_out", 16'({out_result, 6'd0, out_rd}), 16'd0);
        chk("rst_alu", 16'({alu_a | alu_b, 5'd0, alu_opcode}), 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_ready", 16'(in_ready), 16'd1);

        issue(OP_LDI, 2'd1, 2'd0, 1'b1, 8'h7F, 0, 1'b0);
        issue(OP_LDI, 2'd2, 2'd0, 1'b1, 8'h01, 0, 1'b0);
        issue(OP_ADD, 2'd3, 2'd1, 1'b0, 8'h02, 0, 1'b0);
        chk("plan_add_flags", 16'(flags), 16'h000C);
        issue(OP_SUB, 2'd0, 2'd2, 1'b0, 8'h02, 0, 1'b0);
        chk("plan_sub0_flags", 16'(flags), 16'h0003);
        issue(OP_SUB, 2'd0, 2'd2, 1'b1, 8'h02, 0, 1'b0);
        chk("plan_sub1_res", 16'(out_result), 16'h00FF);
        chk("plan_sub1_flags", 16'(flags), 16'h0004);
        issue(OP_SLT, 2'd1, 2'd1, 1'b1, 8'h80, 0, 1'b0);
        chk("plan_slt", 16'(out_result), 16'h0001);
        issue(OP_XOR, 2'd1, 2'd1, 1'b0, 8'h01, 0, 1'b0);
        chk("plan_xor_z", 16'(flags[FLG_Z]), 16'd1);
        issue(OP_SUB, 2'd0, 2'd0, 1'b1, 8'h00, 0, 1'b0);
        chk("sub_b0_c", 16'(flags[FLG_C]), 16'd1);
        issue(OP_ADD, 2'd2, 2'd3, 1'b1, 8'h33, 5, 1'b1);
        issue(OP_NOP, 2'd0, 2'd0, 1'b0, 8'h00, 0, 1'b0);
        issue(OP_ADD, 2'd1, 2'd2, 1'b0, 8'h03, 0, 1'b0);

        for (int n = 0; n < 48; n++) begin
            issue(3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        issue(OP_SUB, 2'd0, 2'd0, 1'b1, 8'h01, 0, 1'b0);
        chk("pre_rst_flags_set", 16'(flags != 4'd0), 16'd1);
        in_valid = 1'b1;
        in_instr = {OP_LDI, 2'd2, 2'd0, 1'b1, 8'h55};
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 16'(out_valid), 16'd0);
        chk("midrst_flags", 16'(flags), 16'd0);
        for (int i = 0; i < 4; i++) rm[i] = 0;
        fm = 4'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(OP_ADD, 2'd0, 2'd2, 1'b1, 8'h00, 0, 1'b0);
        chk("midrst_r2", 16'(out_result), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
